// File: rtl/spram_fifo_ctrl.sv
// Byte FIFO controller in front of a 64x8 single-port RAM: one RAM access per cycle,
// alternating write/read grants under contention, read data staged in an output register.
module spram_fifo_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic [6:0] count,
  output logic       full,
  output logic       empty,
  output logic [7:0] ram_data,
  output logic [5:0] ram_addr,
  output logic       ram_we,
  input  logic [7:0] ram_q
);

  typedef enum logic {IDLE, FETCH} rd_st_e;

  rd_st_e     st, st_nxt;
  logic [5:0] wptr, rptr;
  logic       last_grant;   // 0 = write won last, 1 = read won last
  logic       rd_req, wr_req, rd_gnt, wr_gnt;

  assign full  = (count == 7'(DEPTH));
  assign empty = (count == 7'd0) && (st == IDLE) && !rd_valid;

  always_comb begin
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    rd_gnt   = 1'b0;
    wr_gnt   = 1'b0;
    st_nxt   = IDLE;
    ram_we   = 1'b0;
    ram_addr = rptr;
    ram_data = wr_data;
    wr_ready = 1'b0;
    if (rst_n) begin
      rd_req = (count != 7'd0) && (st == IDLE) && (!rd_valid || rd_ready);
      wr_req = wr_valid && !full;
      // Under contention the side that lost last time wins.
      rd_gnt = rd_req && (!wr_req || !last_grant);
      wr_gnt = wr_req && !rd_gnt;
      st_nxt = rd_gnt ? FETCH : IDLE;
      wr_ready = !full && !rd_gnt;
      if (wr_gnt) begin
        ram_we   = 1'b1;
        ram_addr = wptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= 8'h00;
    end else begin
      st <= st_nxt;
      if (wr_gnt) begin
        wptr       <= wptr + 6'd1;
        count      <= count + 7'd1;
        last_grant <= 1'b0;
      end else if (rd_gnt) begin
        rptr       <= rptr + 6'd1;
        count      <= count - 7'd1;
        last_grant <= 1'b1;
      end
      // A completing fetch reloads the register even if the consumer takes it now.
      if (st == FETCH) begin
        rd_data  <= ram_q;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl: behavioural RAM, queue-based reference model checked every
// cycle, plus directed phases with hand-derived expectations and random backpressure.
module tb_spram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_ready = 1'b0;
  logic       wr_ready, rd_valid, full, empty, ram_we;
  logic [7:0] rd_data, ram_data, ram_q;
  logic [6:0] count;
  logic [5:0] ram_addr;

  int checks = 0;
  int failures = 0;

  spram_fifo_ctrl #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM: q is the addressed word one cycle later.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes stored in RAM as a queue, one in-flight byte, one output byte.
  logic [7:0] mq[$];
  bit         m_on = 0, m_fetch = 0, m_ov = 0, m_last = 1;
  logic [7:0] m_fbyte = 0, m_od = 0;
  int         m_wp = 0, m_rp = 0;
  logic [7:0] sent[$];
  logic [7:0] got[$];

  always @(negedge clk) begin : model
    bit rreq, wreq, gr, gw;
    if (m_on) begin
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == 64));
      chk("empty", int'(empty), int'(mq.size() == 0 && !m_fetch && !m_ov));
      chk("rd_valid", int'(rd_valid), int'(m_ov));
      chk("rd_data", int'(rd_data), int'(m_od));
    end
    if (!rst_n) begin
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_wr_ready", int'(wr_ready), 0);
      mq.delete();
      m_on = 1; m_fetch = 0; m_ov = 0; m_od = 8'h00; m_last = 1; m_wp = 0; m_rp = 0;
    end else if (m_on) begin
      rreq = (mq.size() != 0) && !m_fetch && (!m_ov || rd_ready);
      wreq = wr_valid && (mq.size() < 64);
      gr = rreq && (!wreq || !m_last);
      gw = wreq && !gr;
      chk("ram_we", int'(ram_we), int'(gw));
      chk("ram_addr", int'(ram_addr), gw ? m_wp : m_rp);
      if (gw) chk("ram_data", int'(ram_data), int'(wr_data));
      chk("wr_ready", int'(wr_ready), int'(mq.size() < 64 && !gr));
      if (rd_valid && rd_ready) got.push_back(rd_data);
      if (m_fetch) begin m_ov = 1; m_od = m_fbyte; end
      else if (m_ov && rd_ready) m_ov = 0;
      m_fetch = gr;
      if (gr) begin m_fbyte = mq.pop_front(); m_rp = (m_rp + 1) % 64; m_last = 1; end
      if (gw) begin mq.push_back(wr_data); m_wp = (m_wp + 1) % 64; m_last = 0; end
    end
  end

  bit we_log[$];
  int cmin, cmax;

  // rmode: 0 = rd_ready low, 1 = high, 2 = random.
  task automatic run(input int nwr, input int rmode, input int cycles,
                     input logic [7:0] base, output int acc);
    acc = 0;
    for (int c = 0; c < cycles; c++) begin
      wr_valid = (acc < nwr);
      wr_data  = base + 8'(acc);
      rd_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
      @(negedge clk);
      we_log.push_back(ram_we);
      if (int'(count) < cmin) cmin = int'(count);
      if (int'(count) > cmax) cmax = int'(count);
      if (wr_valid && wr_ready) begin sent.push_back(wr_data); acc++; end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic cmp_q(input string nm);
    chk({nm, "_len"}, got.size(), sent.size());
    for (int i = 0; i < got.size() && i < sent.size(); i++)
      chk({nm, "_byte"}, int'(got[i]), int'(sent[i]));
    got.delete();
    sent.delete();
  endtask

  initial begin : stim
    int acc, bad;
    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_count", int'(count), 0);
    chk("rel_empty", int'(empty), 1);
    chk("rel_full", int'(full), 0);
    chk("rel_rd_valid", int'(rd_valid), 0);
    chk("rel_rd_data", int'(rd_data), 0);
    chk("rel_ram_we", int'(ram_we), 0);
    chk("rel_wr_ready", int'(wr_ready), 1);

    // Latency: write A5 in cycle N, data visible in N+3
    @(posedge clk); #1;
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    chk("lat_n_we", int'(ram_we), 1);
    chk("lat_n_addr", int'(ram_addr), 0);
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_we", int'(ram_we), 0);
    chk("lat_n1_addr", int'(ram_addr), 0);
    @(negedge clk);
    chk("lat_n2_rd_valid", int'(rd_valid), 0);
    @(negedge clk);
    chk("lat_n3_rd_valid", int'(rd_valid), 1);
    chk("lat_n3_rd_data", int'(rd_data), 8'hA5);
    sent.push_back(8'hA5);
    @(posedge clk); #1;
    cmp_q("lat");

    // Fill with rd_ready low: one read slips in, 65 writes accepted
    run(200, 0, 100, 8'h00, acc);
    chk("fill_acc", acc, 65);
    @(negedge clk);
    chk("fill_count", int'(count), 64);
    chk("fill_full", int'(full), 1);
    chk("fill_wr_ready", int'(wr_ready), 0);
    chk("fill_rd_valid", int'(rd_valid), 1);
    chk("fill_rd_data", int'(rd_data), 0);
    @(posedge clk); #1;
    run(0, 1, 200, 8'h00, acc);
    chk("drain_empty", int'(empty), 1);
    cmp_q("drain");

    // Contention after a 4-byte preload
    run(4, 0, 10, 8'h80, acc);
    chk("pre_acc", acc, 4);
    we_log.delete(); cmin = 999; cmax = -1;
    run(20, 1, 20, 8'h90, acc);
    bad = 0;
    for (int i = 1; i < we_log.size(); i++) if (we_log[i] == we_log[i-1]) bad++;
    chk("cont_alternate", bad, 0);
    chk("cont_first_is_read", int'(we_log[0]), 0);
    chk("cont_cnt_min", cmin, 2);
    chk("cont_cnt_max", cmax, 3);
    run(0, 1, 100, 8'h00, acc);
    cmp_q("cont");

    // Wrap-around with random backpressure
    run(150, 2, 1200, 8'h00, acc);
    chk("wrap_acc", acc, 150);
    run(0, 1, 300, 8'h00, acc);
    chk("wrap_empty", int'(empty), 1);
    cmp_q("wrap");

    // Reset during FETCH
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
    @(posedge clk); #1; wr_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ram_we", int'(ram_we), 0);
    chk("midrst_wr_ready", int'(wr_ready), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_count", int'(count), 0);
    @(posedge clk); #1;
    run(1, 1, 8, 8'h3C, acc);
    chk("midrst_acc", acc, 1);
    chk("midrst_got_3c", got.size() == 1 ? int'(got[0]) : -1, 8'h3C);
    cmp_q("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
